rf_dump_reader: RTL and testbench
=================================

Name: rf_dump_reader

Overview:
- Sequential read-out engine for the 32x32 CPU register file, the reader-side counterpart to its write port.
- On a start request it walks a register address range.
- It drives the file's combinational read-address port and captures each word.
- Each captured word is streamed to a debug sink (UART/trace) over a valid/ready handshake.
- Sits beside the pipeline on a spare RF read port; it never writes the register file.

Parameters:
- AW, 5, register address width.
- DW, 32, register data width.
- FIRST, 0, first register index dumped.
- LAST, 31, last register index dumped; FIRST <= LAST <= 2^AW-1 is required.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset (rst=0 resets immediately, independent of clk).
- start  input  1  single-cycle dump request; honoured only in IDLE.
- abort  input  1  synchronous cancel; overrides everything except reset.
- rf_addr  output  AW  read address into the register file's read port.
- rf_data  input  DW  combinational read data for rf_addr, valid in the same cycle.
- out_valid  output  1  out_addr/out_data hold a captured word.
- out_ready  input  1  sink accepts the word when out_valid & out_ready at a rising edge.
- out_addr  output  AW  register index of the presented word.
- out_data  output  DW  captured register contents.
- busy  output  1  high in READ and SEND.
- done  output  1  one-cycle pulse after the LAST word is accepted.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE; rf_addr=FIRST; out_valid=0; out_addr=0; out_data=0; busy=0; done=0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rf_addr holds FIRST.
  - start=1 -> READ next cycle.
  - start=0 -> stay in IDLE.
- READ (one cycle):
  - out_data<=rf_data and out_addr<=rf_addr at the edge leaving READ.
  - out_valid<=1 at the same edge; go to SEND.
- SEND:
  - out_valid=1.
  - out_addr and out_data are held stable until the handshake; a deasserted out_ready must never change them.
  - Handshake with rf_addr==LAST -> DONE, out_valid<=0.
  - Handshake otherwise -> rf_addr<=rf_addr+1, out_valid<=0, go to READ.
- DONE (one cycle):
  - done=1, then IDLE with rf_addr<=FIRST.
- Throughput: 2 cycles per word with out_ready held high.
  - Start sampled at edge E -> word k valid in cycle E+2+2k, accepted at that cycle's closing edge.
  - done is high in cycle E+2+2*(LAST-FIRST)+1.
- Consistency:
  - Each word is the RF value sampled in its READ cycle, not a snapshot at start.
  - A pipeline write to a not-yet-read register is reflected in the dump.
  - A same-cycle write to the address being read returns the pre-write value, since the RF writes on the edge.
- start while busy or in DONE is ignored; no queuing.
- abort=1 in any state:
  - Next state IDLE; out_valid<=0; rf_addr<=FIRST; done not pulsed.
  - A pending unaccepted word is dropped.
  - abort with start in IDLE -> stay IDLE.
- Reset asserted mid-dump:
  - Immediate return to reset values, with no done pulse.
  - After rst deasserts, the block waits for a fresh start.
- rf_addr increments only by the SEND handshake; it never wraps past LAST.
  - LAST=2^AW-1 is legal; no overflow occurs because the DONE path is taken first.
- FIRST==LAST: a single word, then done.

Test Plan:
- RF preloaded with reg[i]=0x1000_0000+i, out_ready=1, start at edge E:
  - 32 words out_addr 0..31, out_data 0x1000_0000..0x1000_001F.
  - Word k valid in cycle E+2+2k.
  - done high exactly once in cycle E+65; busy low afterwards.
- Backpressure: out_ready low for 5 cycles while word 3 is presented:
  - out_valid stays 1 and out_data stays 0x1000_0003 for all 5 cycles.
  - Word 4 appears 2 cycles after ready rises; no words are lost or duplicated.
- Live write: pipeline writes reg[20]=0xDEADBEEF while word 10 is pending:
  - Word 20 reads 0xDEADBEEF.
- Live write, same cycle: writing reg[5] in its READ cycle returns the old value 0x1000_0005.
- abort asserted during SEND of word 7:
  - Next cycle IDLE, out_valid=0, no done.
  - A following start dumps from reg 0 again.
- rst pulled low asynchronously mid-cycle during word 12:
  - All outputs go to reset values immediately.
  - start pulses during reset are ignored.
  - Restart after release produces the full 32-word dump.
- Parameter variant FIRST=8, LAST=8:
  - Exactly one word with out_addr=8.
  - done is high in cycle E+3.
  - A start asserted while busy has no effect.

Source files
------------

// File: rtl/rf_dump_reader.sv
// Sequential register-file dump engine: walks FIRST..LAST on a spare combinational read port
// and streams each captured word to a debug sink over a valid/ready handshake.
module rf_dump_reader #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned FIRST = 0,
  parameter int unsigned LAST  = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] FirstAddr = AW'(FIRST);
  localparam logic [AW-1:0] LastAddr  = AW'(LAST);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic          capture;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    capture = 1'b0;
    if (abort) begin
      // Cancel drops any presented word and rewinds without a done pulse.
      state_d = StIdle;
      addr_d  = FirstAddr;
    end else begin
      case (state_q)
        StIdle: begin
          addr_d = FirstAddr;
          if (start) state_d = StRead;
        end
        StRead: begin
          capture = 1'b1;
          state_d = StSend;
        end
        StSend: begin
          if (out_ready) begin
            // The LAST check comes first, so the address never wraps.
            if (addr_q == LastAddr) begin
              state_d = StDone;
            end else begin
              addr_d  = addr_q + AW'(1);
              state_d = StRead;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          addr_d  = FirstAddr;
        end
        default: begin
          state_d = StIdle;
          addr_d  = FirstAddr;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= FirstAddr;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (capture) begin
        out_addr_q <= addr_q;
        out_data_q <= rf_data;
      end
    end
  end

  assign rf_addr   = addr_q;
  assign out_valid = (state_q == StSend);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StRead) || (state_q == StSend);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomised and directed bench for rf_dump_reader against a transaction-level dump model,
// plus a single-register FIRST=LAST=8 variant.
module tb_rf_dump_reader;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, out_ready;
  logic [AW-1:0] rf_addr, out_addr;
  logic [DW-1:0] rf_data, out_data;
  logic          out_valid, busy, done;

  logic          start1;
  logic [AW-1:0] rf_addr1, out_addr1;
  logic [DW-1:0] rf_data1, out_data1;
  logic          out_valid1, busy1, done1;

  logic [DW-1:0] rf [32];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  int n_vec = 0;
  int n_err = 0;
  int n_edges = 0;

  always #5 clk = ~clk;

  assign rf_data  = rf[rf_addr];
  assign rf_data1 = rf[rf_addr1];
  always @(posedge clk) if (we) rf[wa] <= wd;

  rf_dump_reader #(.AW(AW), .DW(DW), .FIRST(0), .LAST(31)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  rf_dump_reader #(.AW(AW), .DW(DW), .FIRST(8), .LAST(8)) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .rf_addr(rf_addr1),
    .rf_data(rf_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1),
    .out_data(out_data1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Dump model: a dump is "active" from start until the last word is taken; each word is read
  // one cycle before it is offered, and the next read follows each accepted word.
  bit            m_active, m_rdpend, m_valid, m_done;
  logic [AW-1:0] m_idx, m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_active = 0; m_rdpend = 0; m_valid = 0; m_done = 0;
    m_idx = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit new_done;
    new_done = 0;
    if (!rst) begin
      model_reset();
    end else if (abort) begin
      m_active = 0; m_rdpend = 0; m_valid = 0; m_done = 0; m_idx = 0;
    end else begin
      if (m_done) begin
        m_idx = 0;
      end else if (!m_active) begin
        if (start) begin m_active = 1; m_rdpend = 1; end
      end else if (m_rdpend) begin
        m_valid = 1; m_addr = m_idx; m_data = rf[m_idx]; m_rdpend = 0;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
        if (m_idx == 5'd31) begin m_active = 0; new_done = 1; end
        else begin m_idx = m_idx + 5'd1; m_rdpend = 1; end
      end
      m_done = new_done;
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", out_valid, m_valid);
    check_eq("out_addr", out_addr, m_addr);
    check_eq("out_data", out_data, m_data);
    check_eq("rf_addr", rf_addr, m_idx);
    check_eq("busy", busy, m_active);
    check_eq("done", done, m_done);
  endtask

  int log_addr[$], log_data[$], log_cyc[$], done_cyc[$];

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_cyc.delete(); done_cyc.delete();
  endtask

  // One clock: log handshakes of the current cycle, step the model, then check at negedge.
  task automatic tick();
    int cur;
    cur = n_edges + 1;
    if (out_valid && out_ready) begin
      log_addr.push_back(int'(out_addr)); log_data.push_back(int'(out_data));
      log_cyc.push_back(cur);
    end
    if (done) done_cyc.push_back(cur);
    model_step();
    @(posedge clk);
    n_edges++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 300 && done_cyc.size() == 0; i++) tick();
    tick();
  endtask

  task automatic check_full_dump(input string tag);
    check_eq({tag, "_count"}, log_addr.size(), 32);
    for (int k = 0; k < log_addr.size() && k < 32; k++) begin
      check_eq({tag, "_addr"}, log_addr[k], k);
      check_eq({tag, "_data"}, log_data[k], 32'h1000_0000 + k);
    end
  endtask

  initial begin
    int e;
    int rise_cyc;
    bit bp_done, lw_done;
    rst = 1; start = 0; abort = 0; out_ready = 1; we = 0; wa = 0; wd = 0; start1 = 0;
    preload();
    model_reset();
    #2 rst = 0;
    @(negedge clk);
    compare_all();
    check_eq("rst_rf_addr1", rf_addr1, 8);
    rst = 1;
    tick(); tick();

    // Full dump with ready held high: timing and contents.
    clear_logs();
    e = n_edges + 1;
    start = 1; tick(); start = 0;
    run_to_done();
    check_full_dump("full");
    for (int k = 0; k < log_cyc.size() && k < 32; k++) check_eq("full_cyc", log_cyc[k], e + 2 + 2 * k);
    check_eq("full_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_eq("full_done_cyc", done_cyc[0], e + 65);
    check_eq("full_busy_after", busy, 0);

    // Backpressure on word 3, same-cycle write to reg 5, live write to reg 20 during word 10.
    preload(); clear_logs();
    bp_done = 0; lw_done = 0; rise_cyc = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 300 && done_cyc.size() == 0; i++) begin
      we = 0;
      if (!bp_done && out_valid && out_addr == 5'd3) begin
        out_ready = 0;
        for (int j = 0; j < 5; j++) begin
          check_eq("bp_valid", out_valid, 1);
          check_eq("bp_data", out_data, 32'h1000_0003);
          tick();
        end
        out_ready = 1; bp_done = 1; rise_cyc = n_edges + 1;
      end
      if (busy && !out_valid && rf_addr == 5'd5) begin
        we = 1; wa = 5'd5; wd = 32'hA5A5_0005;
      end else if (!lw_done && out_valid && out_addr == 5'd10) begin
        we = 1; wa = 5'd20; wd = 32'hDEAD_BEEF; lw_done = 1;
      end
      tick();
    end
    we = 0;
    tick();
    check_eq("live_count", log_addr.size(), 32);
    for (int k = 0; k < log_addr.size() && k < 32; k++) begin
      check_eq("live_addr", log_addr[k], k);
      check_eq("live_data", log_data[k], (k == 20) ? 32'hDEAD_BEEF : 32'h1000_0000 + k);
    end
    if (log_cyc.size() > 4) check_eq("bp_word4_cyc", log_cyc[4], rise_cyc + 2);
    check_eq("bp_seen", bp_done, 1);

    // Abort while word 7 is presented, then abort+start in idle, then a fresh dump.
    preload(); clear_logs();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 100 && !(out_valid && out_addr == 5'd7); i++) tick();
    out_ready = 0; tick();
    abort = 1; tick(); abort = 0; out_ready = 1;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rf_addr", rf_addr, 0);
    tick(); tick(); tick();
    check_eq("abort_no_done", done_cyc.size(), 0);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check_eq("abort_start_idle", busy, 0);
    clear_logs();
    start = 1; tick(); start = 0;
    run_to_done();
    check_full_dump("redump");

    // Asynchronous reset during word 12, start pulses while held, then a full restart.
    preload(); clear_logs();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 100 && !(out_valid && out_addr == 5'd12); i++) tick();
    #3 rst = 0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_rf_addr", rf_addr, 0);
    check_eq("arst_out_addr", out_addr, 0);
    check_eq("arst_out_data", out_data, 0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin start = (i % 2 == 0); tick(); end
    start = 0; rst = 1;
    tick();
    check_eq("arst_idle_after", busy, 0);
    check_eq("arst_no_done", done_cyc.size(), 0);
    clear_logs();
    start = 1; tick(); start = 0;
    run_to_done();
    check_full_dump("restart");

    // Single-register variant: one word at index 8, done in E+3, starts while busy ignored.
    preload();
    start1 = 1; tick();
    check_eq("one_read_busy", busy1, 1);
    check_eq("one_read_valid", out_valid1, 0);
    tick();
    check_eq("one_valid", out_valid1, 1);
    check_eq("one_addr", out_addr1, 8);
    check_eq("one_data", out_data1, 32'h1000_0008);
    check_eq("one_rf_addr", rf_addr1, 8);
    tick();
    check_eq("one_done", done1, 1);
    check_eq("one_done_valid", out_valid1, 0);
    check_eq("one_done_busy", busy1, 0);
    tick();
    start1 = 0;
    check_eq("one_after_done", done1, 0);
    check_eq("one_after_busy", busy1, 0);
    tick(); tick();
    check_eq("one_no_repeat", out_valid1, 0);
    check_eq("one_idle_busy", busy1, 0);

    // Randomised traffic against the model.
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 8) == 0;
      abort     = ($urandom % 40) == 0;
      out_ready = ($urandom % 3) != 0;
      we        = ($urandom % 4) == 0;
      wa        = AW'($urandom);
      wd        = $urandom;
      tick();
    end
    start = 0; abort = 0; we = 0; out_ready = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
